led_frame_loader: RTL and testbench
===================================

// Module: led_frame_loader
// PURPOSE
// Host-facing upstream stage of the 16x16 single-colour LED panel scan driver. Receives 24-bit
// serial command words over a 3-wire SPI-style link (mode 0, MSB first) and writes rows into a
// double-buffered 16x16 frame store. The scan driver reads the front buffer through a
// combinational pixel port; the buffers swap only at frame boundaries, so frames never tear.
// PARAMETERS
// SYNC_STAGES  2   synchroniser depth on spi_sck_in/spi_sdi_in/spi_csn_in (>=2)
// WORD_BITS    24  bits per command word; fixed layout below, not meant to be overridden
// PORTS
// clk              in   1   system clock; must be >= 4x spi_sck_in
// reset_n          in   1   asynchronous active-low reset
// spi_sck_in       in   1   host serial clock, asynchronous
// spi_sdi_in       in   1   host serial data, sampled on the rising edge of sck
// spi_csn_in       in   1   host chip select, active low, frames one word
// frame_sync_in    in   1   1-clk pulse from the scan driver at row wrap (end of frame)
// rd_row_in        in   4   scan-driver pixel read row
// rd_col_in        in   4   scan-driver pixel read column
// rd_pix_out       out  1   front_buf[rd_row_in][rd_col_in], combinational
// swap_done_out    out  1   1-clk pulse when the buffers swap
// cmd_err_out      out  1   1-clk pulse when a malformed word is discarded
// busy_out         out  1   high while a commit is pending (swap not yet taken)
// BEHAVIOUR
// - Reset (async assert, sync release): both buffers all-zero; front select = 0; shift reg
//   and bit count = 0; pending = 0; all outputs 0. rd_pix_out reads 0 after reset.
// - Inputs pass through SYNC_STAGES flops. A rising edge of synchronised sck while synchronised
//   csn = 0 shifts sdi into sr[23:0] (LSB-in) and increments bit_cnt (5 bits, saturates at 31).
// - Falling edge of synced csn: clear bit_cnt. Rising edge of synced csn: if bit_cnt == 24,
//   execute the word on the next clk; otherwise pulse cmd_err_out and discard the word.
// - Word layout: [23:20] opcode, [19:16] row, [15:0] data (bit n = column n).
//   0x1 WRITE : back_buf[row] <= data.
//   0x2 COMMIT: pending <= 1.
//   0x3 CLEAR : all 16 back_buf rows <= 0 in one clk.
//   0x4 FILL  : all back_buf rows <= data.
//   Any other opcode: cmd_err_out pulse, no state change.
// - Swap: on the clk after frame_sync_in = 1 with pending = 1: toggle front select, pending
//   <= 0, pulse swap_done_out. frame_sync_in with pending = 0 has no effect.
// - Simultaneous events: COMMIT executing in the same clk as frame_sync_in -> pending is set
//   and the swap waits for the next frame_sync_in. A WRITE/CLEAR/FILL executing in the same clk
//   as a swap targets the pre-swap back buffer. Commands during pending = 1 still target the
//   back buffer and are allowed (the host polls busy_out).
// - After a swap the new back buffer holds the previous front contents; no copy is made.
// - Reset mid-word: state is discarded; a host word in flight is lost with no error pulse.
//   csn held low across reset release gives bit_cnt = 0 from the first sck edge onward.
// - busy_out = pending. Latency from the csn rising pin edge to the write taking effect:
//   SYNC_STAGES + 2 clk.
// STRUCTURE
// - Shared package led_panel_pkg: PANEL_ROWS = 16, PANEL_COLS = 16, opcode localparams
//   OP_WRITE/OP_COMMIT/OP_CLEAR/OP_FILL, and typedef row_t = logic [15:0].
// - One sub-module: led_spi_rx (synchronisers, edge detect, shift register, bit count; emits
//   word_valid/word_err pulses and word[23:0]). The parent holds the two 16x16 flop arrays,
//   the command decode and the swap logic.
// TESTING
// - WRITE row 3 = 0x8001, COMMIT, pulse frame_sync_in -> swap_done_out pulses once;
//   rd_row 3/col 0 = 1, col 15 = 1, col 1 = 0.
// - WRITE before COMMIT, no sync -> rd_pix_out is unchanged (front buffer untouched) and
//   busy_out = 1 after COMMIT.
// - Word of 23 bits, then one of 25 bits -> two cmd_err_out pulses; buffers unchanged.
// - Opcode 0x7 -> cmd_err_out pulse; FILL 0xFFFF + COMMIT + sync -> all 256 pixels read 1.
// - COMMIT executes in the same clk as frame_sync_in -> no swap; the swap happens on the
//   next sync pulse.
// - Assert reset_n mid-word at an arbitrary clk phase -> all outputs 0 immediately; the
//   next full WRITE executes correctly.

Source files
------------

// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared panel geometry, command opcodes and row type
package led_panel_pkg;
  localparam int PANEL_ROWS = 16;
  localparam int PANEL_COLS = 16;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_COMMIT = 4'h2;
  localparam logic [3:0] OP_CLEAR  = 4'h3;
  localparam logic [3:0] OP_FILL   = 4'h4;
  typedef logic [PANEL_COLS-1:0] row_t;
  function automatic logic op_known(input logic [3:0] op);
    return op == OP_WRITE || op == OP_COMMIT || op == OP_CLEAR || op == OP_FILL;
  endfunction
endpackage

// File: rtl/led_spi_rx.sv
// led_spi_rx: synchronises the host serial link and frames 24-bit command words
module led_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_sck_in,
  input  logic                 spi_sdi_in,
  input  logic                 spi_csn_in,
  output logic                 word_valid_out,
  output logic                 word_err_out,
  output logic [WORD_BITS-1:0] word_out
);
  localparam logic [4:0] FULL = 5'(WORD_BITS);
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, sdi_sync_q, sdi_sync_d, csn_sync_q, csn_sync_d;
  logic                   sck_prev_q, csn_prev_q;
  logic [WORD_BITS-1:0]   sr_q, sr_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   word_valid_q, word_valid_d, word_err_q, word_err_d;
  logic                   sck_s, sdi_s, csn_s, shift_en, csn_fall, csn_rise;
  // Synchroniser shifts, edge detection, serial shift and word framing
  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_in};
    sdi_sync_d   = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_in};
    csn_sync_d   = {csn_sync_q[SYNC_STAGES-2:0], spi_csn_in};
    sck_s        = sck_sync_q[SYNC_STAGES-1];
    sdi_s        = sdi_sync_q[SYNC_STAGES-1];
    csn_s        = csn_sync_q[SYNC_STAGES-1];
    shift_en     = sck_s & ~sck_prev_q & ~csn_s;
    csn_fall     = ~csn_s & csn_prev_q;
    csn_rise     = csn_s & ~csn_prev_q;
    sr_d         = shift_en ? {sr_q[WORD_BITS-2:0], sdi_s} : sr_q;
    bit_cnt_d    = csn_fall ? 5'd0 : (shift_en && bit_cnt_q != 5'd31) ? bit_cnt_q + 5'd1 : bit_cnt_q;
    word_valid_d = csn_rise & (bit_cnt_q == FULL);
    word_err_d   = csn_rise & (bit_cnt_q != FULL);
  end
  // csn resets to idle-high so a released reset never fakes a word boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      csn_sync_q   <= '1;
      sck_prev_q   <= 1'b0;
      csn_prev_q   <= 1'b1;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_err_q   <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      csn_sync_q   <= csn_sync_d;
      sck_prev_q   <= sck_s;
      csn_prev_q   <= csn_s;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
      word_err_q   <= word_err_d;
    end
  end
  assign word_valid_out = word_valid_q;
  assign word_err_out   = word_err_q;
  assign word_out       = sr_q;
endmodule

// File: rtl/led_frame_loader.sv
// led_frame_loader: decodes host commands into a double-buffered 16x16 frame store
module led_frame_loader
  import led_panel_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck_in,
  input  logic       spi_sdi_in,
  input  logic       spi_csn_in,
  input  logic       frame_sync_in,
  input  logic [3:0] rd_row_in,
  input  logic [3:0] rd_col_in,
  output logic       rd_pix_out,
  output logic       swap_done_out,
  output logic       cmd_err_out,
  output logic       busy_out
);
  logic        word_valid, word_err;
  logic [23:0] word;
  row_t        buf_q [2][PANEL_ROWS];
  row_t        buf_d [2][PANEL_ROWS];
  logic        sel_q, sel_d, pending_q, pending_d, swap_done_q, swap_done_d, cmd_err_q, cmd_err_d;
  logic [3:0]  op, row;
  row_t        data;
  logic        back, swap, wr_row;
  led_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .WORD_BITS(WORD_BITS)) u_rx (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_sck_in     (spi_sck_in),
    .spi_sdi_in     (spi_sdi_in),
    .spi_csn_in     (spi_csn_in),
    .word_valid_out (word_valid),
    .word_err_out   (word_err),
    .word_out       (word)
  );
  // Command decode into the back buffer (pre-swap select) and frame-boundary swap
  always_comb begin
    op          = word[23:20];
    row         = word[19:16];
    data        = word[15:0];
    back        = ~sel_q;
    swap        = frame_sync_in & pending_q;
    buf_d       = buf_q;
    wr_row      = 1'b0;
    for (int r = 0; r < PANEL_ROWS; r++) begin
      wr_row = word_valid & ((op == OP_WRITE && row == 4'(r)) || op == OP_CLEAR || op == OP_FILL);
      if (wr_row) buf_d[back][r] = (op == OP_CLEAR) ? '0 : data;
    end
    pending_d   = (word_valid && op == OP_COMMIT) | (pending_q & ~swap);
    sel_d       = sel_q ^ swap;
    swap_done_d = swap;
    cmd_err_d   = word_err | (word_valid & ~op_known(op));
  end
  // Frame store, select and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q       <= '{default: '0};
      sel_q       <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end
  assign rd_pix_out    = buf_q[sel_q][rd_row_in][rd_col_in];
  assign swap_done_out = swap_done_q;
  assign cmd_err_out   = cmd_err_q;
  assign busy_out      = pending_q;
endmodule

// File: tb/tb_led_frame_loader.sv
// tb_led_frame_loader: directed stimulus with a scoreboard of expected swap/error pulses
module tb_led_frame_loader;
  logic clk = 0, reset_n = 0, sck = 0, sdi = 0, csn = 1, fs = 0;
  logic [3:0] rd_row = 0, rd_col = 0;
  logic rd_pix, swap_done, cmd_err, busy;
  int total = 0, passed = 0;
  int exp_q[$];
  localparam int EV_SWAP = 1, EV_ERR = 2;

  led_frame_loader dut (
    .clk(clk), .reset_n(reset_n), .spi_sck_in(sck), .spi_sdi_in(sdi), .spi_csn_in(csn),
    .frame_sync_in(fs), .rd_row_in(rd_row), .rd_col_in(rd_col), .rd_pix_out(rd_pix),
    .swap_done_out(swap_done), .cmd_err_out(cmd_err), .busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every swap/error pulse must match the next expected event
  always @(negedge clk) begin
    if (swap_done || cmd_err) begin
      int got, want;
      got = (swap_done ? EV_SWAP : 0) | (cmd_err ? EV_ERR : 0);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      chk("event", got, want);
    end
  end

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = w[i];
      #40 sck = 1;
      #40 sck = 0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    csn = 0;
    #40 shift_bits(w, n);
    #40 csn = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_sync();
    @(negedge clk) fs = 1;
    @(negedge clk) fs = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_pix(input string name, input int r, input int c, input int exp);
    rd_row = 4'(r);
    rd_col = 4'(c);
    #1 chk(name, int'(rd_pix), exp);
  endtask

  initial begin
    int ones;
    bit hit;
    #23;
    check_pix("reset_pix", 0, 0, 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_swap", int'(swap_done), 0);
    chk("reset_err", int'(cmd_err), 0);
    @(negedge clk) reset_n = 1;
    repeat (4) @(negedge clk);

    send_word(32'h138001, 24);
    send_word(32'h200000, 24);
    chk("commit_busy", int'(busy), 1);
    check_pix("pre_swap_r3c0", 3, 0, 0);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    chk("swap_busy", int'(busy), 0);
    check_pix("r3c0", 3, 0, 1);
    check_pix("r3c15", 3, 15, 1);
    check_pix("r3c1", 3, 1, 0);

    send_word(32'h15FFFF, 24);
    check_pix("nocommit_r5c0", 5, 0, 0);
    chk("nocommit_busy", int'(busy), 0);
    send_word(32'h200000, 24);
    chk("commit2_busy", int'(busy), 1);
    check_pix("pending_r5c0", 5, 0, 0);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    check_pix("swap2_r5c7", 5, 7, 1);
    check_pix("swap2_r3c0", 3, 0, 0);

    exp_q.push_back(EV_ERR);
    send_word(32'h138001, 23);
    exp_q.push_back(EV_ERR);
    send_word(32'h0138001, 25);
    chk("err_busy", int'(busy), 0);
    check_pix("err_r5c7", 5, 7, 1);
    check_pix("err_r3c15", 3, 15, 0);

    exp_q.push_back(EV_ERR);
    send_word(32'h7F0000, 24);
    send_word(32'h40FFFF, 24);
    send_word(32'h200000, 24);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    ones = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        rd_row = 4'(r);
        rd_col = 4'(c);
        #1 ones += int'(rd_pix);
      end
    chk("fill_all_ones", ones, 256);

    send_word(32'h300000, 24);
    csn = 0;
    #40 shift_bits(32'h200000, 24);
    #40 csn = 1;
    hit = 0;
    for (int k = 0; k < 12 && !hit; k++) begin
      @(negedge clk);
      if (dut.word_valid) begin
        fs = 1;
        hit = 1;
      end
    end
    chk("commit_sync_seen", int'(hit), 1);
    @(negedge clk) fs = 0;
    repeat (3) @(negedge clk);
    chk("commit_sync_busy", int'(busy), 1);
    check_pix("commit_sync_noswap", 5, 0, 1);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    check_pix("clear_r5c0", 5, 0, 0);
    chk("clear_busy", int'(busy), 0);

    send_word(32'h200000, 24);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    check_pix("pre_rst_r9c9", 9, 9, 1);
    send_word(32'h200000, 24);
    chk("pre_rst_busy", int'(busy), 1);
    csn = 0;
    #40 shift_bits(32'h3FF, 10);
    #3 reset_n = 0;
    #1 chk("rst_pix", int'(rd_pix), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_swap", int'(swap_done), 0);
    chk("rst_err", int'(cmd_err), 0);
    #30 reset_n = 1;
    repeat (5) @(negedge clk);
    shift_bits(32'h190200, 24);
    #40 csn = 1;
    repeat (8) @(negedge clk);
    send_word(32'h200000, 24);
    exp_q.push_back(EV_SWAP);
    pulse_sync();
    check_pix("post_rst_r9c9", 9, 9, 1);
    check_pix("post_rst_r9c8", 9, 8, 0);
    check_pix("post_rst_r0c0", 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
